// File: rtl/layer_4_maxpool2x2_if.sv
// Stream bundle for the layer-4 2x2 max-pool stage.
//   data_in / valid_in              : raster-order FP32 pixel stream into the pool
//   data_out / valid_out / frame_done : pooled pixel stream out of the pool
// master = producer/consumer side (drives inputs), slave = the pooling block.
interface layer_4_maxpool2x2_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  frame_done;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, frame_done
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, frame_done
    );
endinterface

// File: rtl/layer_4_maxpool2x2.sv
// Streaming 2x2 / stride-2 max-pool over an IMG_SIZE x IMG_SIZE FP32 map.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - slave side of layer_4_maxpool2x2_if (pixel in, pooled pixel out,
//          frame_done pulse with the last pooled pixel of a frame)
// Even rows fold each horizontal pair into a half-row line buffer; odd rows
// fold their pair with the buffered value and emit one result per pair.
module layer_4_maxpool2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_SIZE   = 104
) (
    input  logic                 Clk,
    input  logic                 Rst,
    layer_4_maxpool2x2_if.slave  bus
);
    localparam int CW = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam int AW = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);
    localparam logic [DATA_WIDTH-1:0] SIGN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Map an IEEE-754 pattern to an unsigned key with the same ordering:
    // negatives are bit-inverted, positives get the sign bit set.
    function automatic logic [DATA_WIDTH-1:0] fkey(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? ~x : (x ^ SIGN);
    endfunction

    // Ties keep the first operand, i.e. the earlier pixel.
    function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    logic [CW-1:0]         col, row;
    logic [DATA_WIDTH-1:0] pair_reg;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_out_r, frame_done_r;
    logic [DATA_WIDTH-1:0] linebuf [IMG_SIZE/2];

    logic [AW-1:0]         lb_idx;
    logic [DATA_WIDTH-1:0] pair_max, pool_max;
    logic                  col_last, row_last, odd_beat;

    always_comb begin
        lb_idx   = AW'(col >> 1);
        pair_max = fmax(pair_reg, bus.data_in);
        pool_max = fmax(linebuf[lb_idx], pair_max);
        col_last = (col == LAST);
        row_last = (row == LAST);
        odd_beat = bus.valid_in && col[0];
    end

    // Line buffer carries no reset: every entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge Clk) begin
        if (odd_beat && !row[0])
            linebuf[lb_idx] <= pair_max;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            col          <= '0;
            row          <= '0;
            pair_reg     <= '0;
            data_out_r   <= '0;
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            valid_out_r  <= 1'b0;
            frame_done_r <= 1'b0;
            if (bus.valid_in) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (!col[0])
                    pair_reg <= bus.data_in;
                if (col[0] && row[0]) begin
                    data_out_r   <= pool_max;
                    valid_out_r  <= 1'b1;
                    frame_done_r <= col_last && row_last;
                end
            end
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.valid_out  = valid_out_r;
    assign bus.frame_done = frame_done_r;
endmodule
